// File: rtl/axi_rid_rsp_pkg.sv
// rtl/axi_rid_rsp_pkg.sv - shared types and constants for the AXI read-ID responder
package axi_rid_rsp_pkg;

  localparam int AXI_ID_W   = 4;
  localparam int AXI_ADDR_W = 10;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_LEN_W  = 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {IDLE, BURST} state_e;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [AXI_LEN_W-1:0]  len;
  } rd_req_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_DATA_W-1:0] data;
    logic [1:0]            resp;
    logic                  last;
  } rd_beat_t;

endpackage

// File: rtl/axi_rid_rsp_gen_if.sv
// rtl/axi_rid_rsp_gen_if.sv - AR/R channel bundle between interconnect and read responder
interface axi_rid_rsp_gen_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
);
  logic [ID_W-1:0]   s_arid;
  logic [ADDR_W-1:0] s_araddr;
  logic [LEN_W-1:0]  s_arlen;
  logic              s_arvalid;
  logic              s_arready;
  logic [ID_W-1:0]   s_rid;
  logic [DATA_W-1:0] s_rdata;
  logic [1:0]        s_rresp;
  logic              s_rlast;
  logic              s_rvalid;
  logic              s_rready;

  modport slave (
    input  s_arid, s_araddr, s_arlen, s_arvalid, s_rready,
    output s_arready, s_rid, s_rdata, s_rresp, s_rlast, s_rvalid
  );

  modport master (
    output s_arid, s_araddr, s_arlen, s_arvalid, s_rready,
    input  s_arready, s_rid, s_rdata, s_rresp, s_rlast, s_rvalid
  );
endinterface

// File: rtl/axi_rid_rsp_queue.sv
// rtl/axi_rid_rsp_queue.sv - synchronous FIFO of pending read requests
module axi_rid_rsp_queue
  import axi_rid_rsp_pkg::*;
#(
  parameter int Q_DEPTH_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push_i,
  input  rd_req_t            push_data_i,
  input  logic               pop_i,
  output rd_req_t            head_o,
  output logic [Q_DEPTH_W:0] count_o,
  output logic               full_o,
  output logic               empty_o
);
  localparam int DEPTH = 2**Q_DEPTH_W;
  localparam int CW    = Q_DEPTH_W + 1;

  rd_req_t                mem_q [DEPTH];
  logic [Q_DEPTH_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [Q_DEPTH_W:0]     cnt_q;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + Q_DEPTH_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + Q_DEPTH_W'(1);
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/axi_rid_rsp_gen.sv
// rtl/axi_rid_rsp_gen.sv - AXI4 read responder returning RAM beats tagged with the AR ID
// Build option AXI_RID_RSP_RANGE_CHK_EN: beats at or above MEM_WORDS answer SLVERR without a RAM read.
module axi_rid_rsp_gen
  import axi_rid_rsp_pkg::*;
#(
  parameter int ID_W      = AXI_ID_W,
  parameter int ADDR_W    = AXI_ADDR_W,
  parameter int DATA_W    = AXI_DATA_W,
  parameter int LEN_W     = AXI_LEN_W,
  parameter int Q_DEPTH_W = 2,
  parameter int MEM_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  axi_rid_rsp_gen_if.slave  s,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              busy
);
  localparam int DEPTH = 2**Q_DEPTH_W;
  localparam int CW    = Q_DEPTH_W + 1;
`ifdef AXI_RID_RSP_RANGE_CHK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif
  localparam logic [ADDR_W:0] MEM_LIM = (ADDR_W+1)'(MEM_WORDS);

  rd_req_t            ar_req, q_head;
  logic               q_push, q_pop, q_full, q_empty, arready_q;
  logic [Q_DEPTH_W:0] q_cnt, cnt_next;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [ID_W-1:0]    bid_q, bid_d;
  logic               issue, credit_ok, beat_err;

  logic               pend_q, pend_last_q, pend_err_q;
  logic [ID_W-1:0]    pend_id_q;
  rd_beat_t           buf_q [2];
  rd_beat_t           cap;
  logic [1:0]         buf_cnt_q, held;
  logic               r_pop;

  assign ar_req = '{id: s.s_arid, addr: s.s_araddr, len: s.s_arlen};
  assign q_push = s.s_arvalid & arready_q & ~q_full;

  axi_rid_rsp_queue #(.Q_DEPTH_W(Q_DEPTH_W)) u_queue (
    .clk(clk), .rst(rst), .push_i(q_push), .push_data_i(ar_req), .pop_i(q_pop),
    .head_o(q_head), .count_o(q_cnt), .full_o(q_full), .empty_o(q_empty)
  );

  always_comb begin
    cnt_next = q_cnt;
    if (q_push && !q_pop)      cnt_next = q_cnt + CW'(1);
    else if (!q_push && q_pop) cnt_next = q_cnt - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) arready_q <= 1'b0;
    else     arready_q <= (cnt_next != CW'(DEPTH));
  end

  // Credits count buffer slots left after this cycle's R pop, so a draining burst runs 1 beat/clk.
  assign r_pop     = s.s_rvalid & s.s_rready;
  assign held      = buf_cnt_q - 2'(r_pop);
  assign credit_ok = (held + 2'(pend_q)) < 2'd2;
  assign beat_err  = RANGE_CHK && ({1'b0, addr_q} >= MEM_LIM);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    bid_d   = bid_q;
    q_pop   = 1'b0;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!q_empty) begin
          q_pop   = 1'b1;
          addr_d  = q_head.addr;
          rem_d   = q_head.len;
          bid_d   = q_head.id;
          state_d = BURST;
        end
      end
      BURST: begin
        if (credit_ok) begin
          issue  = 1'b1;
          addr_d = addr_q + ADDR_W'(1);
          rem_d  = rem_q - LEN_W'(1);
          if (rem_q == '0) begin
            if (!q_empty) begin
              q_pop  = 1'b1;
              addr_d = q_head.addr;
              rem_d  = q_head.len;
              bid_d  = q_head.id;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      bid_q       <= '0;
      pend_q      <= 1'b0;
      pend_id_q   <= '0;
      pend_last_q <= 1'b0;
      pend_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      bid_q       <= bid_d;
      pend_q      <= issue;
      pend_id_q   <= bid_q;
      pend_last_q <= (rem_q == '0);
      pend_err_q  <= beat_err;
    end
  end

  assign mem_rd_en   = issue & ~beat_err;
  assign mem_rd_addr = addr_q;

  always_comb begin
    cap.id   = pend_id_q;
    cap.data = pend_err_q ? '0 : mem_rd_data;
    cap.resp = pend_err_q ? RESP_SLVERR : RESP_OKAY;
    cap.last = pend_last_q;
  end

  // Slot 0 is always the head; a pop shifts slot 1 down before the new capture lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q[0]  <= '0;
      buf_q[1]  <= '0;
      buf_cnt_q <= '0;
    end else begin
      if (r_pop) buf_q[0] <= buf_q[1];
      if (pend_q) begin
        if (held == 2'd0) buf_q[0] <= cap;
        else              buf_q[1] <= cap;
      end
      buf_cnt_q <= held + 2'(pend_q);
    end
  end

  assign s.s_arready = arready_q;
  assign s.s_rvalid  = (buf_cnt_q != 2'd0);
  assign s.s_rid     = buf_q[0].id;
  assign s.s_rdata   = buf_q[0].data;
  assign s.s_rresp   = buf_q[0].resp;
  assign s.s_rlast   = buf_q[0].last;

  assign busy = ~q_empty | (state_q == BURST) | pend_q | (buf_cnt_q != 2'd0);

endmodule
